// File: rtl/ysyx_24120009_axi_lite_sram.sv
// AXI4-Lite data-memory responder: word-addressed SRAM with independent read and
// write channels, byte strobes and fixed, parameterised response latencies.
module ysyx_24120009_axi_lite_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] RD_LOAD = (RD_LATENCY > 1) ? 32'(RD_LATENCY - 2) : 32'd0;
    localparam logic [31:0] WR_LOAD = (WR_LATENCY > 1) ? 32'(WR_LATENCY - 2) : 32'd0;
    localparam bit          RD_FAST = (RD_LATENCY <= 1);
    localparam bit          WR_FAST = (WR_LATENCY <= 1);
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wState_e;

    function automatic logic inRange(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] wordIdx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    rState_e     rState_q;
    logic [31:0] rCnt_q;
    logic [31:0] araddr_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    wState_e     wState_q;
    logic [31:0] wCnt_q;
    logic        awHeld_q;
    logic        wHeld_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic [31:0] rdAddr_d;
    logic        rdHit_d;
    logic [31:0] rdWord_d;
    logic        awFire_d;
    logic        wFire_d;
    logic        bothHeld_d;
    logic [31:0] wAddr_d;
    logic [31:0] wData_d;
    logic [3:0]  wStrb_d;
    logic        wHit_d;
    logic        commit_d;

    // In idle the address is taken straight from the bus so a latency of one still
    // samples the array on the handshake edge.
    always_comb begin
        rdAddr_d = (rState_q == R_IDLE) ? araddr : araddr_q;
        rdHit_d  = inRange(rdAddr_d);
        rdWord_d = rdHit_d ? mem[wordIdx(rdAddr_d)] : 32'd0;
    end

    assign awFire_d   = (wState_q == W_IDLE) && awvalid && awready_q;
    assign wFire_d    = (wState_q == W_IDLE) && wvalid && wready_q;
    assign bothHeld_d = (wState_q == W_IDLE) && (awHeld_q || awFire_d) && (wHeld_q || wFire_d);

    always_comb begin
        wAddr_d  = awHeld_q ? awaddr_q : awaddr;
        wData_d  = wHeld_q ? wdata_q : wdata;
        wStrb_d  = wHeld_q ? wstrb_q : wstrb;
        wHit_d   = inRange(wAddr_d);
        commit_d = !rst && ((bothHeld_d && WR_FAST) || (wState_q == W_WAIT && wCnt_q == 32'd0));
    end

    // The array itself is never reset; an uncommitted write is dropped by the FSM reset.
    always_ff @(posedge clk) begin
        if (commit_d && wHit_d) begin
            for (int b = 0; b < 4; b++) begin
                if (wStrb_d[b]) begin
                    mem[wordIdx(wAddr_d)][8*b +: 8] <= wData_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q  <= R_IDLE;
            rCnt_q    <= 32'd0;
            araddr_q  <= 32'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= OKAY;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    if (arvalid) begin
                        araddr_q  <= araddr;
                        arready_q <= 1'b0;
                        if (RD_FAST) begin
                            rState_q <= R_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rdWord_d;
                            rresp_q  <= rdHit_d ? OKAY : SLVERR;
                        end else begin
                            rState_q <= R_WAIT;
                            rCnt_q   <= RD_LOAD;
                        end
                    end
                end
                R_WAIT: begin
                    if (rCnt_q == 32'd0) begin
                        rState_q <= R_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rdWord_d;
                        rresp_q  <= rdHit_d ? OKAY : SLVERR;
                    end else begin
                        rCnt_q <= rCnt_q - 32'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rState_q  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    // AW and W are captured independently; the transaction starts once both are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState_q  <= W_IDLE;
            wCnt_q    <= 32'd0;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (wState_q)
                W_IDLE: begin
                    if (awFire_d) begin
                        awHeld_q  <= 1'b1;
                        awaddr_q  <= awaddr;
                        awready_q <= 1'b0;
                    end
                    if (wFire_d) begin
                        wHeld_q  <= 1'b1;
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                        wready_q <= 1'b0;
                    end
                    if (bothHeld_d) begin
                        if (WR_FAST) begin
                            wState_q <= W_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= wHit_d ? OKAY : SLVERR;
                        end else begin
                            wState_q <= W_WAIT;
                            wCnt_q   <= WR_LOAD;
                        end
                    end
                end
                W_WAIT: begin
                    if (wCnt_q == 32'd0) begin
                        wState_q <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wHit_d ? OKAY : SLVERR;
                    end else begin
                        wCnt_q <= wCnt_q - 32'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wState_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awHeld_q  <= 1'b0;
                        wHeld_q   <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_24120009_axi_lite_sram.sv
// Bench for the AXI4-Lite SRAM: directed scenarios plus random reads/writes checked
// against a plain word-array model of the memory.
module tb_ysyx_24120009_axi_lite_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 64;
    localparam int          RL    = 3;
    localparam int          WL    = 2;

    logic        clk;
    logic        rst;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] model [DEPTH];

    ysyx_24120009_axi_lite_sram #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .RD_LATENCY (RL),
        .WR_LATENCY (WL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit hit(input logic [31:0] a);
        return (a - BASE) < 32'(4 * DEPTH);
    endfunction

    function automatic int slot(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] oorAddr();
        case ($urandom_range(0, 3))
            0:       return BASE - 32'd4;
            1:       return BASE + 32'(4 * DEPTH);
            2:       return 32'h0000_1000;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awDelay, input int wDelay, input int bDelay);
        bit awDone;
        bit wDone;
        int hsCycle;
        int j;
        awDone = 1'b0;
        wDone  = 1'b0;
        hsCycle = 0;
        for (int k = 0; k < 100 && !(awDone && wDone); k++) begin
            @(negedge clk);
            awvalid = !awDone && (k >= awDelay);
            awaddr  = awvalid ? addr : $urandom;
            wvalid  = !wDone && (k >= wDelay);
            wdata   = wvalid ? data : $urandom;
            wstrb   = wvalid ? strb : 4'($urandom);
            if (awDone && !wDone) checkOutput("awreadyHeld", 32'(awready), 32'd0);
            if (wDone && !awDone) checkOutput("wreadyHeld", 32'(wready), 32'd0);
            if (awvalid && awready) begin awDone = 1'b1; hsCycle = cyc; end
            if (wvalid && wready) begin wDone = 1'b1; hsCycle = cyc; end
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(awDone && wDone)) begin
            checkOutput("writeAccept", {30'd0, awDone, wDone}, 32'd3);
            return;
        end
        bready = (bDelay == 0);
        for (j = 0; j < 64 && !bvalid; j++) @(negedge clk);
        if (!bvalid) begin
            checkOutput("bvalidTimeout", 32'(bvalid), 32'd1);
            bready = 1'b0;
            return;
        end
        checkOutput("bLatency", 32'(cyc - hsCycle), 32'(WL));
        checkOutput("bresp", 32'(bresp), hit(addr) ? 32'd0 : 32'd2);
        for (j = 0; j < bDelay; j++) begin
            @(negedge clk);
            checkOutput("bvalidHold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(negedge clk);
        checkOutput("bvalidDrop", 32'(bvalid), 32'd0);
        checkOutput("awreadyBack", {30'd0, awready, wready}, 32'd3);
        bready = 1'b0;
        if (hit(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[slot(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic doRead(input logic [31:0] addr, input int rDelay, input bit junkAr, output logic [31:0] seen);
        int          arCycle;
        int          j;
        logic [31:0] expData;
        logic [31:0] expResp;
        expData = hit(addr) ? model[slot(addr)] : 32'd0;
        expResp = hit(addr) ? 32'd0 : 32'd2;
        seen    = 32'd0;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = addr;
        checkOutput("arreadyIdle", 32'(arready), 32'd1);
        arCycle = cyc;
        @(negedge clk);
        arvalid = junkAr;
        araddr  = $urandom;
        rready  = (rDelay == 0);
        for (j = 0; j < 64 && !rvalid; j++) begin
            checkOutput("arreadyBusy", 32'(arready), 32'd0);
            @(negedge clk);
        end
        if (!rvalid) begin
            checkOutput("rvalidTimeout", 32'(rvalid), 32'd1);
            arvalid = 1'b0;
            rready  = 1'b0;
            return;
        end
        checkOutput("rLatency", 32'(cyc - arCycle), 32'(RL));
        checkOutput("rresp", 32'(rresp), expResp);
        checkOutput("rdata", rdata, expData);
        seen = rdata;
        if (rDelay == 0) arvalid = 1'b0;
        for (j = 0; j < rDelay; j++) begin
            @(negedge clk);
            checkOutput("rvalidHold", 32'(rvalid), 32'd1);
            checkOutput("rdataHold", rdata, expData);
            checkOutput("arreadyHold", 32'(arready), 32'd0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        checkOutput("rvalidDrop", 32'(rvalid), 32'd0);
        checkOutput("arreadyBack", 32'(arready), 32'd1);
        rready = 1'b0;
    endtask

    logic [31:0] got;
    logic [31:0] cAddr;
    logic [31:0] oldWord;
    logic [31:0] newWord;
    bit          gotR;
    bit          gotB;

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; araddr = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstArready", 32'(arready), 32'd1);
        checkOutput("rstAwready", 32'(awready), 32'd1);
        checkOutput("rstWready", 32'(wready), 32'd1);
        checkOutput("rstRvalid", 32'(rvalid), 32'd0);
        checkOutput("rstBvalid", 32'(bvalid), 32'd0);
        checkOutput("rstRdata", rdata, 32'd0);
        checkOutput("rstResp", {28'd0, rresp, bresp}, 32'd0);

        for (int i = 0; i < DEPTH; i++) doWrite(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

        doWrite(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        doRead(BASE + 32'h10, 0, 1'b0, got);
        checkOutput("deadbeef", got, 32'hDEADBEEF);

        doWrite(BASE + 32'h20, 32'h11223344, 4'hF, 0, 0, 0);
        doWrite(BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 1);
        doRead(BASE + 32'h20, 0, 1'b0, got);
        checkOutput("partialStrobe", got, 32'h11BB33DD);

        doWrite(BASE + 32'h30, $urandom, 4'hF, 0, 3, 0);
        doWrite(BASE + 32'h34, $urandom, 4'hF, 2, 0, 2);
        doWrite(BASE + 32'h38, $urandom, 4'h0, 0, 0, 0);

        doRead(32'h7FFF_FFFC, 1, 1'b0, got);
        doWrite(BASE + 32'(4 * DEPTH), 32'h5A5A_5A5A, 4'hF, 0, 0, 0);
        doRead(BASE, 0, 1'b0, got);

        doRead(BASE + 32'h10, 5, 1'b1, got);

        // Read sample and write commit land on the same edge: the read sees the old word.
        cAddr   = BASE + 32'h50;
        oldWord = model[20];
        newWord = ~oldWord;
        rready  = 1'b1;
        bready  = 1'b1;
        for (int k = 0; k <= RL - WL; k++) begin
            @(negedge clk);
            arvalid = (k == 0);
            araddr  = cAddr;
            if (k == RL - WL) begin
                awvalid = 1'b1; wvalid = 1'b1;
                awaddr = cAddr; wdata = newWord; wstrb = 4'hF;
            end
        end
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        gotR = 1'b0;
        gotB = 1'b0;
        for (int j = 0; j < 64 && !(gotR && gotB); j++) begin
            if (rvalid && !gotR) begin
                gotR = 1'b1;
                checkOutput("collideOld", rdata, oldWord);
            end
            if (bvalid) gotB = 1'b1;
            if (!(gotR && gotB)) @(negedge clk);
        end
        checkOutput("collideDone", {30'd0, gotR, gotB}, 32'd3);
        @(negedge clk);
        rready = 1'b0;
        bready = 1'b0;
        model[20] = newWord;
        doRead(cAddr, 0, 1'b0, got);
        checkOutput("collideNew", got, newWord);

        // Reset while both channels are waiting: nothing is answered or written.
        @(negedge clk);
        arvalid = 1'b1; araddr = BASE + 32'h40;
        awvalid = 1'b1; wvalid = 1'b1;
        awaddr = BASE + 32'h40; wdata = ~model[16]; wstrb = 4'hF;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("postRstReady", {29'd0, arready, awready, wready}, 32'd7);
        repeat (6) begin
            @(negedge clk);
            checkOutput("postRstValid", {30'd0, rvalid, bvalid}, 32'd0);
        end
        doRead(BASE + 32'h40, 0, 1'b0, got);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = oorAddr();
            else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                doWrite(a, $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                doRead(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
